// File: rtl/attack_resolver.sv
// Battleship attack resolver: latches a placement board, resolves shots against it, tracks
// hit/miss maps and shot budget, and drives a blinking 5x7 result display.
module attack_resolver #(
  parameter int unsigned MAX_SHOTS = 12,
  parameter int unsigned BLINK_DIV = 190
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       save_game,
  input  logic       attack_button,
  input  logic [6:0] board_col1,
  input  logic [6:0] board_col2,
  input  logic [6:0] board_col3,
  input  logic [6:0] board_col4,
  input  logic [6:0] board_col5,
  input  logic [2:0] columns_attack,
  input  logic [2:0] rows_attack,
  output logic [6:0] col1_out,
  output logic [6:0] col2_out,
  output logic [6:0] col3_out,
  output logic [6:0] col4_out,
  output logic [6:0] col5_out,
  output logic       hit,
  output logic       miss,
  output logic       invalid,
  output logic [3:0] shots_left,
  output logic [5:0] hits_count,
  output logic       armed,
  output logic       game_over,
  output logic       win
);

  localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StResolve, StDone} state_e;

  state_e state_q, state_d;

  // Flat cell vectors: bit (col*7 + row)
  logic [34:0] board_in, board_q, hit_map_q, miss_map_q, disp_d, col_out_q;
  logic [2:0]  col_q, row_q;
  logic [3:0]  shots_q, shots_n;
  logic [5:0]  hits_q, hits_n, target_q, target_new, cell_idx;
  logic        win_q, pending_q, pending_d, blink_q;
  logic [CntW-1:0] blink_cnt_q;
  logic        hit_q, miss_q, invalid_q, armed_q, over_q;
  logic        hit_d, miss_d, invalid_d, armed_d, over_d;
  logic        do_save, attack_ok, oob, res_invalid, res_hit;

  assign board_in = {board_col5, board_col4, board_col3, board_col2, board_col1};

  always_comb begin
    target_new = '0;
    for (int i = 0; i < 35; i++) target_new = target_new + 6'(board_in[i]);
  end

  // A save raised during RESOLVE is held in pending_q and applied on the following cycle
  assign do_save   = (state_q != StResolve) && (save_game || pending_q) && (board_in != '0);
  assign attack_ok = (state_q == StArmed) && attack_button && !save_game && !pending_q;
  assign pending_d = (state_q == StResolve) ? (pending_q | save_game) : 1'b0;

  assign oob = (col_q > 3'd4) || (row_q > 3'd6);
  always_comb begin
    cell_idx = '0;
    if (!oob) cell_idx = 6'(col_q) * 6'd7 + 6'(row_q);
  end
  assign res_invalid = oob || hit_map_q[cell_idx] || miss_map_q[cell_idx];
  assign res_hit     = !res_invalid && board_q[cell_idx];
  assign shots_n     = (!res_invalid && shots_q != '0) ? shots_q - 4'd1 : shots_q;
  assign hits_n      = (res_hit && hits_q < target_q) ? hits_q + 6'd1 : hits_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (do_save) state_d = StArmed;
      StArmed: begin
        if (do_save)        state_d = StArmed;
        else if (attack_ok) state_d = StResolve;
      end
      StResolve: begin
        if (res_invalid)             state_d = StArmed;
        else if (hits_n == target_q) state_d = StDone;
        else if (shots_n == '0)      state_d = StDone;
        else                         state_d = StArmed;
      end
      StDone:    if (do_save) state_d = StArmed;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    hit_d     = (state_q == StResolve) && res_hit;
    miss_d    = (state_q == StResolve) && !res_invalid && !res_hit;
    invalid_d = (state_q == StResolve) && res_invalid;
    armed_d   = (state_d == StArmed) || (state_d == StResolve);
    over_d    = (state_d == StDone);
    disp_d    = board_in;
    unique case (state_q)
      StIdle:             disp_d = board_in;
      StArmed, StResolve: disp_d = hit_map_q | (miss_map_q & {35{blink_q}});
      StDone: begin
        if (win_q) disp_d = blink_q ? {35{1'b1}} : hit_map_q;
        else       disp_d = board_q | hit_map_q;
      end
      default:            disp_d = board_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      board_q     <= '0;
      hit_map_q   <= '0;
      miss_map_q  <= '0;
      col_q       <= '0;
      row_q       <= '0;
      shots_q     <= '0;
      hits_q      <= '0;
      target_q    <= '0;
      win_q       <= 1'b0;
      pending_q   <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      invalid_q   <= 1'b0;
      armed_q     <= 1'b0;
      over_q      <= 1'b0;
      col_out_q   <= board_in;
    end else begin
      pending_q <= pending_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      invalid_q <= invalid_d;
      armed_q   <= armed_d;
      over_q    <= over_d;
      col_out_q <= disp_d;
      if (blink_cnt_q == CntMax) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
      if (do_save) begin
        board_q    <= board_in;
        hit_map_q  <= '0;
        miss_map_q <= '0;
        shots_q    <= 4'(MAX_SHOTS);
        hits_q     <= '0;
        target_q   <= target_new;
        win_q      <= 1'b0;
      end else if (attack_ok) begin
        col_q <= columns_attack;
        row_q <= rows_attack;
      end else if (state_q == StResolve && !res_invalid) begin
        shots_q <= shots_n;
        hits_q  <= hits_n;
        win_q   <= (hits_n == target_q);
        if (res_hit) hit_map_q[cell_idx] <= 1'b1;
        else         miss_map_q[cell_idx] <= 1'b1;
      end
    end
  end

  assign {col5_out, col4_out, col3_out, col2_out, col1_out} = col_out_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign invalid    = invalid_q;
  assign shots_left = shots_q;
  assign hits_count = hits_q;
  assign armed      = armed_q;
  assign game_over  = over_q;
  assign win        = win_q;

endmodule

// File: tb/tb_attack_resolver.sv
// Scenario bench for attack_resolver: result pulses go through a timestamped scoreboard queue,
// status/display checked inline per scenario.
module tb_attack_resolver;

  localparam int unsigned MaxShots = 12;
  localparam int unsigned BlinkDiv = 4;
  localparam int RHit = 0, RMiss = 1, RInv = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0, save_game = 1'b0, attack_button = 1'b0;
  logic [6:0] bc1 = '0, bc2 = '0, bc3 = '0, bc4 = '0, bc5 = '0;
  logic [2:0] columns_attack = '0, rows_attack = '0;
  logic [6:0] c1o, c2o, c3o, c4o, c5o;
  logic       hit, miss, invalid, armed, game_over, win;
  logic [3:0] shots_left;
  logic [5:0] hits_count;

  int total = 0, bad = 0, cyc = 0;
  int exp_code_q[$];
  int exp_cyc_q[$];

  attack_resolver #(.MAX_SHOTS(MaxShots), .BLINK_DIV(BlinkDiv)) u_dut (
    .clk(clk), .reset(reset), .save_game(save_game), .attack_button(attack_button),
    .board_col1(bc1), .board_col2(bc2), .board_col3(bc3), .board_col4(bc4), .board_col5(bc5),
    .columns_attack(columns_attack), .rows_attack(rows_attack),
    .col1_out(c1o), .col2_out(c2o), .col3_out(c3o), .col4_out(c4o), .col5_out(c5o),
    .hit(hit), .miss(miss), .invalid(invalid), .shots_left(shots_left),
    .hits_count(hits_count), .armed(armed), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every result pulse must match the oldest expectation, on the expected cycle
  always @(negedge clk) begin
    int code, ecode, ecyc;
    if (hit || miss || invalid) begin
      code = hit ? RHit : (miss ? RMiss : RInv);
      total++;
      if (exp_code_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d got code %0d, required no pulse", cyc, code);
      end else begin
        ecode = exp_code_q.pop_front();
        ecyc  = exp_cyc_q.pop_front();
        if ((32'(hit) + 32'(miss) + 32'(invalid)) != 1 || code != ecode || cyc != ecyc) begin
          bad++;
          $display("FAIL result_pulse got code %0d at cyc %0d (h%0b m%0b i%0b), required %0d at %0d",
                   code, cyc, hit, miss, invalid, ecode, ecyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_board(input logic [6:0] a, b, c, d, e);
    bc1 = a; bc2 = b; bc3 = c; bc4 = d; bc5 = e;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic do_save();
    save_game = 1'b1;
    step();
    save_game = 1'b0;
  endtask

  // Pulse is expected two edges after the attack is sampled; returns with DUT back in ARMED/DONE
  task automatic fire(input logic [2:0] c, input logic [2:0] r, input int code);
    exp_code_q.push_back(code);
    exp_cyc_q.push_back(cyc + 2);
    columns_attack = c;
    rows_attack = r;
    attack_button = 1'b1;
    step();
    attack_button = 1'b0;
    step();
    step();
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_code_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending expectations %0d, required 0", name, exp_code_q.size());
      exp_code_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic test_reset();
    set_board(7'h55, 7'h2a, 7'h01, 7'h40, 7'h7f);
    do_reset();
    step();
    total++;
    if ({shots_left, hits_count, armed, game_over, win, hit, miss, invalid} !== '0) begin
      bad++;
      $display("FAIL reset_status got sh=%0d hc=%0d a%0b g%0b w%0b, required all zero",
               shots_left, hits_count, armed, game_over, win);
    end
    total++;
    if ({c1o, c2o, c3o, c4o, c5o} !== {7'h55, 7'h2a, 7'h01, 7'h40, 7'h7f}) begin
      bad++;
      $display("FAIL reset_display got %h %h %h %h %h, required 55 2a 01 40 7f",
               c1o, c2o, c3o, c4o, c5o);
    end
  endtask

  task automatic test_single_hit();
    do_reset();
    set_board(7'b0000001, '0, '0, '0, '0);
    do_save();
    total++;
    if (armed !== 1'b1 || shots_left !== 4'd12 || hits_count !== 6'd0) begin
      bad++;
      $display("FAIL save_arm got a%0b sh=%0d hc=%0d, required a1 sh=12 hc=0",
               armed, shots_left, hits_count);
    end
    fire(3'd0, 3'd0, RHit);
    total++;
    if (hits_count !== 6'd1 || win !== 1'b1 || game_over !== 1'b1 || shots_left !== 4'd11
        || armed !== 1'b0) begin
      bad++;
      $display("FAIL single_hit got hc=%0d w%0b g%0b sh=%0d a%0b, required 1 1 1 11 0",
               hits_count, win, game_over, shots_left, armed);
    end
    check_drained("single_hit");
  endtask

  task automatic test_miss_invalid();
    do_reset();
    set_board('0, '0, 7'b0001000, '0, '0);
    do_save();
    fire(3'd0, 3'd0, RMiss);
    total++;
    if (shots_left !== 4'd11 || hits_count !== 6'd0) begin
      bad++;
      $display("FAIL miss_shots got sh=%0d hc=%0d, required 11 0", shots_left, hits_count);
    end
    fire(3'd0, 3'd0, RInv);
    fire(3'd5, 3'd0, RInv);
    fire(3'd4, 3'd7, RInv);
    total++;
    if (shots_left !== 4'd11 || game_over !== 1'b0 || armed !== 1'b1) begin
      bad++;
      $display("FAIL invalid_noshot got sh=%0d g%0b a%0b, required 11 0 1",
               shots_left, game_over, armed);
    end
    // Attack held into RESOLVE must yield only one result
    exp_code_q.push_back(RHit);
    exp_cyc_q.push_back(cyc + 2);
    columns_attack = 3'd2;
    rows_attack = 3'd3;
    attack_button = 1'b1;
    step();
    step();
    attack_button = 1'b0;
    step();
    step();
    total++;
    if (shots_left !== 4'd10 || win !== 1'b1 || game_over !== 1'b1) begin
      bad++;
      $display("FAIL held_attack got sh=%0d w%0b g%0b, required 10 1 1",
               shots_left, win, game_over);
    end
    check_drained("miss_invalid");
  endtask

  task automatic test_exhaust();
    do_reset();
    set_board('0, '0, '0, '0, 7'b1000000);
    do_save();
    for (int i = 0; i < int'(MaxShots); i++) fire(3'(i / 7), 3'(i % 7), RMiss);
    step();
    total++;
    if (game_over !== 1'b1 || win !== 1'b0 || shots_left !== 4'd0) begin
      bad++;
      $display("FAIL exhaust_status got g%0b w%0b sh=%0d, required 1 0 0",
               game_over, win, shots_left);
    end
    total++;
    if (c5o !== 7'b1000000 || c1o !== 7'd0) begin
      bad++;
      $display("FAIL exhaust_display got c5=%b c1=%b, required 1000000 0000000", c5o, c1o);
    end
    columns_attack = 3'd4;
    rows_attack = 3'd6;
    attack_button = 1'b1;
    step();
    attack_button = 1'b0;
    step();
    step();
    total++;
    if (shots_left !== 4'd0 || hits_count !== 6'd0 || game_over !== 1'b1) begin
      bad++;
      $display("FAIL done_ignores got sh=%0d hc=%0d g%0b, required 0 0 1",
               shots_left, hits_count, game_over);
    end
    check_drained("exhaust");
  endtask

  task automatic test_save_collision();
    set_board('0, 7'b0000011, '0, '0, '0);
    do_save();
    fire(3'd1, 3'd0, RHit);
    fire(3'd0, 3'd0, RMiss);
    save_game = 1'b1;
    attack_button = 1'b1;
    columns_attack = 3'd1;
    rows_attack = 3'd1;
    step();
    save_game = 1'b0;
    attack_button = 1'b0;
    step();
    step();
    step();
    total++;
    if (shots_left !== 4'd12 || hits_count !== 6'd0 || armed !== 1'b1) begin
      bad++;
      $display("FAIL collision got sh=%0d hc=%0d a%0b, required 12 0 1",
               shots_left, hits_count, armed);
    end
    total++;
    if (c1o !== 7'd0 || c2o !== 7'd0) begin
      bad++;
      $display("FAIL collision_maps got c1=%b c2=%b, required 0 0", c1o, c2o);
    end
    check_drained("collision");
  endtask

  task automatic test_deferred_save();
    do_reset();
    set_board(7'b0000011, '0, '0, '0, '0);
    do_save();
    exp_code_q.push_back(RHit);
    exp_cyc_q.push_back(cyc + 2);
    columns_attack = 3'd0;
    rows_attack = 3'd0;
    attack_button = 1'b1;
    step();
    attack_button = 1'b0;
    save_game = 1'b1;
    step();
    save_game = 1'b0;
    total++;
    if (hits_count !== 6'd1 || shots_left !== 4'd11) begin
      bad++;
      $display("FAIL deferred_resolve got hc=%0d sh=%0d, required 1 11", hits_count, shots_left);
    end
    step();
    total++;
    if (hits_count !== 6'd0 || shots_left !== 4'd12 || armed !== 1'b1) begin
      bad++;
      $display("FAIL deferred_apply got hc=%0d sh=%0d a%0b, required 0 12 1",
               hits_count, shots_left, armed);
    end
    check_drained("deferred");
  endtask

  task automatic test_zero_and_abort();
    do_reset();
    set_board('0, '0, '0, '0, '0);
    do_save();
    step();
    total++;
    if (armed !== 1'b0 || shots_left !== 4'd0) begin
      bad++;
      $display("FAIL zero_board got a%0b sh=%0d, required 0 0", armed, shots_left);
    end
    set_board('0, '0, '0, 7'b0000100, '0);
    do_save();
    columns_attack = 3'd3;
    rows_attack = 3'd2;
    attack_button = 1'b1;
    step();
    attack_button = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    total++;
    if (armed !== 1'b0 || shots_left !== 4'd0 || hits_count !== 6'd0 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL abort_resolve got a%0b sh=%0d hc=%0d g%0b, required 0 0 0 0",
               armed, shots_left, hits_count, game_over);
    end
    check_drained("abort");
  endtask

  task automatic test_blink();
    logic [15:0] trace;
    int toggles;
    do_reset();
    set_board(7'b1000000, '0, '0, '0, '0);
    do_save();
    fire(3'd0, 3'd0, RMiss);
    step();
    for (int i = 0; i < 16; i++) begin
      trace[i] = c1o[0];
      step();
    end
    toggles = 0;
    for (int i = 0; i < 12; i++) if (trace[i+4] == trace[i]) toggles++;
    total++;
    if (toggles != 0) begin
      bad++;
      $display("FAIL blink_period got trace %b (%0d non-toggles at distance 4), required 0",
               trace, toggles);
    end
    toggles = 0;
    for (int i = 0; i < 15; i++) if (trace[i+1] != trace[i]) toggles++;
    total++;
    if (toggles < 3 || toggles > 4 || c1o[6] !== 1'b0) begin
      bad++;
      $display("FAIL blink_edges got %0d edges c1[6]=%b, required 3..4 and 0", toggles, c1o[6]);
    end
    check_drained("blink");
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_miss_invalid();
    test_exhaust();
    test_save_collision();
    test_deferred_save();
    test_zero_and_abort();
    test_blink();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
